// File: rtl/feature_loader_pp.sv
// feature_loader_pp: ping-pong feature staging banks with per-bank element windows
module feature_loader_pp #(
  parameter int inputWidth = 256,
  parameter int addrWidth = 8,
  parameter int elementWidth = 8,
  parameter int numElements = 128,
  parameter int ClearOnSwap = 1,
  localparam int E = inputWidth / elementWidth,
  localparam int LW = $clog2(E) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_valid_i,
  output logic wr_ready_o,
  input  logic [inputWidth-1:0] data_i,
  input  logic [addrWidth-1:0] addr_i,
  input  logic [LW-1:0] wr_len_i,
  input  logic wr_done_i,
  input  logic [15:0] mask_start,
  input  logic [15:0] mask_end,
  input  logic rd_consume_i,
  output logic [numElements*elementWidth-1:0] data_o,
  output logic rd_valid_o,
  output logic overflow_o,
  output logic [15:0] swap_count_o
);
  localparam int NW = $clog2(numElements);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state_q, state_d;
  logic wb_q, rb, rd_valid_q, rd_valid_d, fill, accept, done, consume, swap, ovf_hit;
  logic [elementWidth-1:0] mem [2][numElements];
  logic [15:0] ms_q [2];
  logic [15:0] me_q [2];
  logic [addrWidth:0] wa [E];
  logic we [E];
  assign rb = ~wb_q;
  assign fill = state_q == FILL;
  assign accept = fill && wr_valid_i;
  assign done = fill && wr_done_i;
  assign consume = rd_consume_i && rd_valid_q;
  assign swap = done ? (!rd_valid_q || rd_consume_i) : (!fill && consume);
  assign wr_ready_o = fill;
  assign rd_valid_o = rd_valid_q;
  // next state: a completed fill either swaps straight away or waits in HOLD for the reader
  always_comb begin
    state_d = state_q;
    rd_valid_d = rd_valid_q;
    state_d = swap ? FILL : done ? HOLD : state_q;
    rd_valid_d = swap || (rd_valid_q && !(fill && consume));
  end
  // per-element write address and enable; out-of-range elements are dropped and flagged
  always_comb begin
    ovf_hit = 1'b0;
    for (int i = 0; i < E; i++) begin
      wa[i] = {1'b0, addr_i} + (addrWidth+1)'(i);
      we[i] = accept && LW'(i) < wr_len_i && wa[i] < (addrWidth+1)'(numElements);
      ovf_hit = ovf_hit || (accept && LW'(i) < wr_len_i && wa[i] >= (addrWidth+1)'(numElements));
    end
  end
  // control registers: FSM, bank select, valid, sticky overflow, swap counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= FILL;
      wb_q <= 1'b0;
      rd_valid_q <= 1'b0;
      overflow_o <= 1'b0;
      swap_count_o <= '0;
    end else begin
      state_q <= state_d;
      rd_valid_q <= rd_valid_d;
      overflow_o <= overflow_o || ovf_hit;
      if (swap) wb_q <= ~wb_q;
      if (swap) swap_count_o <= swap_count_o + 16'd1;
    end
  // bank storage: beat writes and mask latch go to the write bank, swap clears the incoming write bank
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        ms_q[b] <= '0;
        me_q[b] <= '0;
        for (int k = 0; k < numElements; k++) mem[b][k] <= '0;
      end
    end else begin
      for (int i = 0; i < E; i++)
        if (we[i]) mem[wb_q][wa[i][NW-1:0]] <= data_i[(E-1-i)*elementWidth +: elementWidth];
      if (done) begin
        ms_q[wb_q] <= mask_start;
        me_q[wb_q] <= mask_end;
      end
      if (swap && ClearOnSwap != 0) begin
        ms_q[rb] <= '0;
        me_q[rb] <= '0;
        for (int k = 0; k < numElements; k++) mem[rb][k] <= '0;
      end
    end
  // read view: read bank gated by its window; an end beyond the bank simply passes every element
  always_comb begin
    data_o = '0;
    for (int k = 0; k < numElements; k++)
      data_o[k*elementWidth +: elementWidth] = (rd_valid_q && 16'(k) >= ms_q[rb] && 16'(k) < me_q[rb]) ? mem[rb][k] : '0;
  end
endmodule
